// File: rtl/processor_window_scheduler.sv
// Ping-pong scheduler: the loader fills one window buffer while the cascade processor
// runs variance then detection on the other; results leave tagged with position and scale.
module processor_window_scheduler #(
    parameter int ROW_BITS   = 10,
    parameter int COL_BITS   = 10,
    parameter int SCALE_BITS = 4,
    parameter int STAGE_BITS = 5,
    parameter int FIXED_BITS = 32
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cfg_start,
    input  logic [ROW_BITS-1:0]   cfg_last_x,
    input  logic [COL_BITS-1:0]   cfg_last_y,
    input  logic [SCALE_BITS-1:0] cfg_scale,
    input  logic [STAGE_BITS-1:0] cfg_num_stages,
    input  logic [FIXED_BITS-1:0] cfg_inv_area,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  load_req,
    output logic [ROW_BITS-1:0]   load_x,
    output logic [COL_BITS-1:0]   load_y,
    output logic                  load_buf,
    input  logic                  load_done,
    output logic                  proc_dblBuf,
    output logic [STAGE_BITS-1:0] proc_numberOfStages,
    output logic [FIXED_BITS-1:0] proc_inv_window_area,
    output logic                  proc_startVar,
    input  logic                  proc_readyVar,
    output logic                  proc_start,
    input  logic                  proc_ready,
    input  logic                  proc_done,
    input  logic                  proc_valid,
    input  logic                  proc_passfail,
    output logic                  out_valid,
    output logic                  out_passfail,
    output logic [ROW_BITS-1:0]   out_x,
    output logic [COL_BITS-1:0]   out_y,
    output logic [SCALE_BITS-1:0] out_scale,
    input  logic                  out_taken
);

    typedef enum logic {L_IDLE, L_REQ} load_state_t;
    typedef enum logic [2:0] {C_IDLE, C_VAR, C_VARW, C_RUN, C_RUNW, C_OUT} comp_state_t;

    load_state_t l_state_q, l_state_d;
    comp_state_t c_state_q, c_state_d;

    logic                  busy_q, busy_d, frame_done_q, frame_done_d;
    logic                  load_req_q, load_req_d, load_buf_q, load_buf_d;
    logic [ROW_BITS-1:0]   load_x_q, load_x_d, px_q, px_d, cfg_last_x_q, cfg_last_x_d;
    logic [COL_BITS-1:0]   load_y_q, load_y_d, py_q, py_d, cfg_last_y_q, cfg_last_y_d;
    logic [SCALE_BITS-1:0] scale_q, scale_d;
    logic [STAGE_BITS-1:0] proc_numberOfStages_q, proc_numberOfStages_d;
    logic [FIXED_BITS-1:0] proc_inv_window_area_q, proc_inv_window_area_d;
    logic                  proc_dblBuf_q, proc_dblBuf_d, proc_startVar_q, proc_startVar_d;
    logic                  proc_start_q, proc_start_d;
    logic                  out_valid_q, out_valid_d, out_passfail_q, out_passfail_d;
    logic [ROW_BITS-1:0]   out_x_q, out_x_d;
    logic [COL_BITS-1:0]   out_y_q, out_y_d;
    logic [SCALE_BITS-1:0] out_scale_q, out_scale_d;
    logic [1:0]            full_q, full_d, set_vec, clr_vec, avail;
    logic                  lbuf_q, lbuf_d, cbuf_q, cbuf_d, all_loaded_q, all_loaded_d;
    logic [ROW_BITS-1:0]   tag_x_q [2];
    logic [ROW_BITS-1:0]   tag_x_d [2];
    logic [COL_BITS-1:0]   tag_y_q [2];
    logic [COL_BITS-1:0]   tag_y_d [2];
    logic                  start_accept;

    always_comb begin
        start_accept           = cfg_start && !busy_q;
        l_state_d              = l_state_q;
        c_state_d              = c_state_q;
        busy_d                 = busy_q;
        frame_done_d           = 1'b0;
        load_req_d             = load_req_q;
        load_x_d               = load_x_q;
        load_y_d               = load_y_q;
        load_buf_d             = load_buf_q;
        px_d                   = px_q;
        py_d                   = py_q;
        cfg_last_x_d           = cfg_last_x_q;
        cfg_last_y_d           = cfg_last_y_q;
        scale_d                = scale_q;
        proc_numberOfStages_d  = proc_numberOfStages_q;
        proc_inv_window_area_d = proc_inv_window_area_q;
        proc_dblBuf_d          = proc_dblBuf_q;
        proc_startVar_d        = 1'b0;
        proc_start_d           = 1'b0;
        out_valid_d            = out_valid_q;
        out_passfail_d         = out_passfail_q;
        out_x_d                = out_x_q;
        out_y_d                = out_y_q;
        out_scale_d            = out_scale_q;
        lbuf_d                 = lbuf_q;
        cbuf_d                 = cbuf_q;
        all_loaded_d           = all_loaded_q;
        tag_x_d                = tag_x_q;
        tag_y_d                = tag_y_q;
        set_vec                = 2'b00;
        clr_vec                = 2'b00;

        if (start_accept) begin
            busy_d                 = 1'b1;
            cfg_last_x_d           = cfg_last_x;
            cfg_last_y_d           = cfg_last_y;
            scale_d                = cfg_scale;
            proc_numberOfStages_d  = cfg_num_stages;
            proc_inv_window_area_d = cfg_inv_area;
            px_d                   = '0;
            py_d                   = '0;
            lbuf_d                 = 1'b0;
            cbuf_d                 = 1'b0;
            all_loaded_d           = 1'b0;
        end

        // Loader: the first request of a frame is issued straight from the start pulse.
        case (l_state_q)
            L_IDLE: begin
                if (start_accept) begin
                    l_state_d  = L_REQ;
                    load_req_d = 1'b1;
                    load_x_d   = '0;
                    load_y_d   = '0;
                    load_buf_d = 1'b0;
                end else if (busy_q && !all_loaded_q && !full_q[lbuf_q]) begin
                    l_state_d  = L_REQ;
                    load_req_d = 1'b1;
                    load_x_d   = px_q;
                    load_y_d   = py_q;
                    load_buf_d = lbuf_q;
                end
            end
            L_REQ: begin
                if (load_done) begin
                    l_state_d        = L_IDLE;
                    load_req_d       = 1'b0;
                    set_vec[lbuf_q]  = 1'b1;
                    tag_x_d[lbuf_q]  = px_q;
                    tag_y_d[lbuf_q]  = py_q;
                    lbuf_d           = ~lbuf_q;
                    if (px_q == cfg_last_x_q) begin
                        px_d = '0;
                        if (py_q == cfg_last_y_q) all_loaded_d = 1'b1;
                        else                      py_d = py_q + 1'b1;
                    end else begin
                        px_d = px_q + 1'b1;
                    end
                end
            end
            default: l_state_d = L_IDLE;
        endcase

        // A buffer completing this cycle can be picked up at once by an idle compute side.
        avail = full_q | set_vec;
        case (c_state_q)
            C_IDLE: begin
                if (busy_q && avail[cbuf_q]) begin
                    c_state_d       = C_VAR;
                    proc_startVar_d = 1'b1;
                    proc_dblBuf_d   = cbuf_q;
                end
            end
            C_VAR:  c_state_d = C_VARW;
            C_VARW: if (proc_readyVar) c_state_d = C_RUN;
            C_RUN: begin
                if (proc_ready) begin
                    proc_start_d = 1'b1;
                    c_state_d    = C_RUNW;
                end
            end
            C_RUNW: begin
                if (proc_done) begin
                    if (proc_valid) begin
                        out_valid_d    = 1'b1;
                        out_passfail_d = proc_passfail;
                        out_x_d        = tag_x_q[cbuf_q];
                        out_y_d        = tag_y_q[cbuf_q];
                        out_scale_d    = scale_q;
                        c_state_d      = C_OUT;
                    end else begin
                        clr_vec[cbuf_q] = 1'b1;
                        cbuf_d          = ~cbuf_q;
                        c_state_d       = C_IDLE;
                    end
                end
            end
            C_OUT: begin
                if (out_taken) begin
                    out_valid_d     = 1'b0;
                    clr_vec[cbuf_q] = 1'b1;
                    cbuf_d          = ~cbuf_q;
                    c_state_d       = C_IDLE;
                end
            end
            default: c_state_d = C_IDLE;
        endcase

        full_d = start_accept ? 2'b00 : (avail & ~clr_vec);

        if (busy_q && all_loaded_d && (full_d == 2'b00) && (c_state_d == C_IDLE)) begin
            frame_done_d = 1'b1;
            busy_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            l_state_q              <= L_IDLE;
            c_state_q              <= C_IDLE;
            busy_q                 <= 1'b0;
            frame_done_q           <= 1'b0;
            load_req_q             <= 1'b0;
            load_x_q               <= '0;
            load_y_q               <= '0;
            load_buf_q             <= 1'b0;
            px_q                   <= '0;
            py_q                   <= '0;
            cfg_last_x_q           <= '0;
            cfg_last_y_q           <= '0;
            scale_q                <= '0;
            proc_numberOfStages_q  <= '0;
            proc_inv_window_area_q <= '0;
            proc_dblBuf_q          <= 1'b0;
            proc_startVar_q        <= 1'b0;
            proc_start_q           <= 1'b0;
            out_valid_q            <= 1'b0;
            out_passfail_q         <= 1'b0;
            out_x_q                <= '0;
            out_y_q                <= '0;
            out_scale_q            <= '0;
            full_q                 <= 2'b00;
            lbuf_q                 <= 1'b0;
            cbuf_q                 <= 1'b0;
            all_loaded_q           <= 1'b0;
            tag_x_q                <= '{default: '0};
            tag_y_q                <= '{default: '0};
        end else begin
            l_state_q              <= l_state_d;
            c_state_q              <= c_state_d;
            busy_q                 <= busy_d;
            frame_done_q           <= frame_done_d;
            load_req_q             <= load_req_d;
            load_x_q               <= load_x_d;
            load_y_q               <= load_y_d;
            load_buf_q             <= load_buf_d;
            px_q                   <= px_d;
            py_q                   <= py_d;
            cfg_last_x_q           <= cfg_last_x_d;
            cfg_last_y_q           <= cfg_last_y_d;
            scale_q                <= scale_d;
            proc_numberOfStages_q  <= proc_numberOfStages_d;
            proc_inv_window_area_q <= proc_inv_window_area_d;
            proc_dblBuf_q          <= proc_dblBuf_d;
            proc_startVar_q        <= proc_startVar_d;
            proc_start_q           <= proc_start_d;
            out_valid_q            <= out_valid_d;
            out_passfail_q         <= out_passfail_d;
            out_x_q                <= out_x_d;
            out_y_q                <= out_y_d;
            out_scale_q            <= out_scale_d;
            full_q                 <= full_d;
            lbuf_q                 <= lbuf_d;
            cbuf_q                 <= cbuf_d;
            all_loaded_q           <= all_loaded_d;
            tag_x_q                <= tag_x_d;
            tag_y_q                <= tag_y_d;
        end
    end

    assign busy                 = busy_q;
    assign frame_done           = frame_done_q;
    assign load_req             = load_req_q;
    assign load_x               = load_x_q;
    assign load_y               = load_y_q;
    assign load_buf             = load_buf_q;
    assign proc_dblBuf          = proc_dblBuf_q;
    assign proc_numberOfStages  = proc_numberOfStages_q;
    assign proc_inv_window_area = proc_inv_window_area_q;
    assign proc_startVar        = proc_startVar_q;
    assign proc_start           = proc_start_q;
    assign out_valid            = out_valid_q;
    assign out_passfail         = out_passfail_q;
    assign out_x                = out_x_q;
    assign out_y                = out_y_q;
    assign out_scale            = out_scale_q;

endmodule

// File: tb/tb_processor_window_scheduler.sv
// Scoreboard bench: models loader, processor and downstream on the falling edge and checks
// load positions and tagged results against expectations queued when each frame starts.
module tb_processor_window_scheduler;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] scale;
        logic       pf;
    } out_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       b;
    } load_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_start = 1'b0;
    logic [9:0]  cfg_last_x = '0;
    logic [9:0]  cfg_last_y = '0;
    logic [3:0]  cfg_scale = '0;
    logic [4:0]  cfg_num_stages = '0;
    logic [31:0] cfg_inv_area = '0;
    logic        busy, frame_done, load_req, load_buf;
    logic [9:0]  load_x, load_y, out_x, out_y;
    logic        load_done = 1'b0;
    logic        proc_dblBuf, proc_startVar, proc_start;
    logic [4:0]  proc_numberOfStages;
    logic [31:0] proc_inv_window_area;
    logic        proc_readyVar = 1'b1;
    logic        proc_ready = 1'b1;
    logic        proc_done = 1'b0;
    logic        proc_valid = 1'b0;
    logic        proc_passfail = 1'b0;
    logic        out_valid, out_passfail;
    logic [3:0]  out_scale;
    logic        out_taken = 1'b0;

    processor_window_scheduler dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start),
        .cfg_last_x(cfg_last_x), .cfg_last_y(cfg_last_y), .cfg_scale(cfg_scale),
        .cfg_num_stages(cfg_num_stages), .cfg_inv_area(cfg_inv_area),
        .busy(busy), .frame_done(frame_done),
        .load_req(load_req), .load_x(load_x), .load_y(load_y), .load_buf(load_buf),
        .load_done(load_done), .proc_dblBuf(proc_dblBuf),
        .proc_numberOfStages(proc_numberOfStages), .proc_inv_window_area(proc_inv_window_area),
        .proc_startVar(proc_startVar), .proc_readyVar(proc_readyVar),
        .proc_start(proc_start), .proc_ready(proc_ready), .proc_done(proc_done),
        .proc_valid(proc_valid), .proc_passfail(proc_passfail),
        .out_valid(out_valid), .out_passfail(out_passfail),
        .out_x(out_x), .out_y(out_y), .out_scale(out_scale), .out_taken(out_taken)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    out_t  exp_out[$];
    load_t exp_load[$];

    // Knobs written only by the stimulus process
    logic [15:0] valid_pat = '1;
    logic [15:0] pf_pat = '0;
    int load_lat = 1, var_lat = 1, run_lat = 1;
    int stall_idx = 0, stall_len = 0;

    // Model state written only by the falling-edge model
    int  ld_timer = 0, var_timer = 0, run_timer = 0, stall_left = 0;
    bit  ld_active = 0, run_active = 0, hold_active = 0;
    int  win = 0, req_idx = 0, res_idx = 0;
    int  ld_cnt = 0, sv_cnt = 0, st_cnt = 0, fd_cnt = 0;
    int  sv_snap = 0, ld_snap = 0;
    int  ld_done_cyc = 0, sv_cyc = 0, take_cyc = 0, fd_cyc = 0, req1_cyc = 0, done0_cyc = 0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    // Loader, processor and downstream behaviour, all driven away from the rising edge
    always @(negedge clk) begin
        load_t le;
        out_t  eo;
        if (!reset_n) begin
            load_done = 0; proc_done = 0; proc_valid = 0; proc_passfail = 0;
            proc_readyVar = 1; out_taken = 0;
            ld_active = 0; run_active = 0; hold_active = 0;
            win = 0; req_idx = 0; res_idx = 0;
        end else begin
            load_done = 0;
            proc_done = 0;
            if (ld_active) begin
                if (ld_timer == 0) begin
                    load_done = 1; ld_active = 0; ld_cnt++; ld_done_cyc = cyc;
                end else ld_timer--;
            end else if (load_req) begin
                ld_active = 1; ld_timer = load_lat;
                if (req_idx == 1) req1_cyc = cyc;
                req_idx++;
                if (exp_load.size() == 0) checkOutput("load_unexpected", 1, 0);
                else begin
                    le = exp_load.pop_front();
                    checkOutput("load_pos", {load_x, load_y, load_buf}, le);
                end
            end

            if (proc_startVar) begin
                proc_readyVar = 0; var_timer = var_lat; sv_cnt++; sv_cyc = cyc;
            end else if (!proc_readyVar) begin
                if (var_timer == 0) proc_readyVar = 1;
                else var_timer--;
            end

            if (proc_start) begin
                run_active = 1; run_timer = run_lat; st_cnt++;
            end else if (run_active) begin
                if (run_timer == 0) begin
                    proc_done = 1;
                    proc_valid = valid_pat[win];
                    proc_passfail = pf_pat[win];
                    if (win == 0) done0_cyc = cyc;
                    win++;
                    run_active = 0;
                end else run_timer--;
            end

            if (out_valid && !out_taken) begin
                if (!hold_active) begin
                    hold_active = 1;
                    stall_left = (res_idx == stall_idx) ? stall_len : 0;
                    sv_snap = sv_cnt; ld_snap = ld_cnt;
                end
                if (exp_out.size() == 0) begin
                    checkOutput("out_unexpected", 1, 0);
                    out_taken = 1;
                end else if (stall_left > 0) begin
                    checkOutput("bp_hold", {out_x, out_y, out_scale, out_passfail}, exp_out[0]);
                    stall_left--;
                    if (stall_left == 0) begin
                        checkOutput("bp_no_startvar", sv_cnt - sv_snap, 0);
                        checkOutput("bp_loads_le1", (ld_cnt - ld_snap) <= 1, 1);
                    end
                end else begin
                    eo = exp_out.pop_front();
                    checkOutput("out_tag", {out_x, out_y, out_scale, out_passfail}, eo);
                    out_taken = 1; take_cyc = cyc; res_idx++;
                end
            end else begin
                out_taken = 0;
                hold_active = 0;
            end

            if (frame_done) begin
                fd_cnt++; fd_cyc = cyc;
                checkOutput("busy_at_done", busy, 0);
                win = 0; req_idx = 0; res_idx = 0;
            end
        end
    end

    task automatic applyStimulus(input int lx, input int ly, input logic [3:0] scale,
                                 input logic [4:0] stages, input logic [31:0] inv);
        int n;
        load_t le;
        out_t  eo;
        n = 0;
        for (int y = 0; y <= ly; y++) begin
            for (int x = 0; x <= lx; x++) begin
                le.x = 10'(x); le.y = 10'(y); le.b = n[0];
                exp_load.push_back(le);
                if (valid_pat[n]) begin
                    eo.x = 10'(x); eo.y = 10'(y); eo.scale = scale; eo.pf = pf_pat[n];
                    exp_out.push_back(eo);
                end
                n++;
            end
        end
        @(negedge clk);
        cfg_last_x = 10'(lx); cfg_last_y = 10'(ly); cfg_scale = scale;
        cfg_num_stages = stages; cfg_inv_area = inv; cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
        checkOutput("busy_cycle1", busy, 1);
        checkOutput("load_req_cycle1", load_req, 1);
        checkOutput("stages_latched", proc_numberOfStages, stages);
        checkOutput("inv_latched", proc_inv_window_area, inv);
    endtask

    task automatic waitFrame(input int target);
        for (int i = 0; i < 3000 && fd_cnt < target; i++) @(negedge clk);
        if (fd_cnt < target) checkOutput("frame_timeout", fd_cnt, target);
        repeat (2) @(negedge clk);
        checkOutput("out_queue_drained", exp_out.size(), 0);
        checkOutput("load_queue_drained", exp_load.size(), 0);
    endtask

    initial begin
        int sv0, st0, fd0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ctrl", {busy, frame_done, load_req, load_buf, proc_dblBuf, proc_startVar,
                                 proc_start, out_valid, out_passfail, proc_numberOfStages}, 0);
        checkOutput("rst_pos", {load_x, load_y, out_x, out_y, out_scale}, 0);
        checkOutput("rst_inv", proc_inv_window_area, 0);
        reset_n = 1;
        repeat (2) @(negedge clk);

        $display("[TB] 1x1 frame");
        sv0 = sv_cnt; st0 = st_cnt;
        applyStimulus(0, 0, 4'd3, 5'd7, 32'h0000_1234);
        waitFrame(fd_cnt + 1);
        checkOutput("one_startvar", sv_cnt - sv0, 1);
        checkOutput("one_start", st_cnt - st0, 1);
        checkOutput("startvar_after_load", sv_cyc, ld_done_cyc + 1);
        checkOutput("done_after_take", fd_cyc, take_cyc + 1);

        $display("[TB] 2x2 frame, immediate responders");
        load_lat = 0; var_lat = 0; run_lat = 0;
        pf_pat = 16'b1001;
        applyStimulus(1, 1, 4'd2, 5'd12, 32'hdead_beef);
        waitFrame(fd_cnt + 1);
        checkOutput("load_overlaps_compute", req1_cyc < done0_cyc, 1);

        $display("[TB] 2x2 frame with backpressure");
        pf_pat = 16'b0110; stall_idx = 0; stall_len = 10;
        sv0 = sv_cnt;
        applyStimulus(1, 1, 4'd6, 5'd3, 32'h0001_0000);
        waitFrame(fd_cnt + 1);
        checkOutput("bp_startvar_total", sv_cnt - sv0, 4);
        stall_len = 0;

        $display("[TB] 3x1 frame, second window invalid");
        load_lat = 1; var_lat = 2; run_lat = 1;
        valid_pat = 16'hfffd; pf_pat = 16'b101;
        fd0 = fd_cnt;
        applyStimulus(2, 0, 4'd1, 5'd9, 32'h0000_0042);
        waitFrame(fd_cnt + 1);
        checkOutput("invalid_frame_done", fd_cnt - fd0, 1);
        valid_pat = '1;

        $display("[TB] cfg_start while busy");
        pf_pat = 16'b0011;
        applyStimulus(1, 1, 4'd5, 5'd4, 32'h0000_0777);
        repeat (3) @(negedge clk);
        cfg_last_x = 10'd3; cfg_scale = 4'd9; cfg_num_stages = 5'd1; cfg_start = 1;
        @(negedge clk);
        cfg_start = 0;
        checkOutput("busy_ignore_stages", proc_numberOfStages, 5'd4);
        waitFrame(fd_cnt + 1);

        $display("[TB] reset during detection");
        run_lat = 8;
        applyStimulus(1, 1, 4'd7, 5'd2, 32'h0000_0011);
        for (int i = 0; i < 200 && !run_active; i++) @(negedge clk);
        checkOutput("reached_runw", run_active, 1);
        #2 reset_n = 0;
        #1;
        checkOutput("async_rst_ctrl", {busy, frame_done, load_req, load_buf, proc_dblBuf, proc_startVar,
                                       proc_start, out_valid, out_passfail, proc_numberOfStages}, 0);
        checkOutput("async_rst_pos", {load_x, load_y, out_x, out_y, out_scale}, 0);
        checkOutput("async_rst_inv", proc_inv_window_area, 0);
        exp_out.delete();
        exp_load.delete();
        fd0 = fd_cnt;
        repeat (3) @(negedge clk);
        reset_n = 1;
        run_lat = 1;
        pf_pat = 16'b1100;
        applyStimulus(1, 1, 4'd8, 5'd6, 32'h0000_0abc);
        waitFrame(fd0 + 1);
        checkOutput("clean_frame_after_reset", fd_cnt - fd0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
